// File: rtl/esp32_spi_master_if.sv
// Request/response and SPI pin bundle for esp32_spi_master.
// slave = the SPI master core; master = the requester that also sits on the SPI wires.
interface esp32_spi_master_if;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [2:0]  req_space;
  logic [23:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic        busy;
  logic        sclk;
  logic        mosi;
  logic        miso;

  modport master (
    output req_valid, req_op, req_space, req_addr, req_wdata, miso,
    input  req_ready, rsp_valid, rsp_data, busy, sclk, mosi
  );

  modport slave (
    input  req_valid, req_op, req_space, req_addr, req_wdata, miso,
    output req_ready, rsp_valid, rsp_data, busy, sclk, mosi
  );
endinterface

// File: rtl/esp32_spi_master.sv
// SPI mode-0 initiator for the ESP32 link register/memory protocol.
// One transaction at a time: optional sync byte, CMD, address/index, data or turnaround+read.
module esp32_spi_master #(
  parameter int CLK_DIV      = 4,
  parameter bit USE_SYNC     = 1'b1,
  parameter int IDLE_GAP_CYC = 16
) (
  input logic clk,
  input logic rst_n,
  esp32_spi_master_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GW = $clog2(IDLE_GAP_CYC + 2);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(IDLE_GAP_CYC);
  localparam logic [1:0] OP_REG_WR = 2'd0;
  localparam logic [1:0] OP_MEM_WR = 2'd2;

  // Byte k of the frame; space only reaches the CMD byte for MEM ops.
  function automatic logic [7:0] frameByte(input logic [1:0] op, input logic [2:0] space,
                                           input logic [23:0] addr, input logic [7:0] wdata,
                                           input logic [2:0] k);
    logic [7:0] b;
    logic [2:0] j;
    b = 8'h00;
    j = USE_SYNC ? (k - 3'd1) : k;
    if (USE_SYNC && (k == 3'd0)) begin
      b = 8'hA5;
    end else begin
      case (j)
        3'd0:    b = {1'b1, op, 2'b00, (op[1] ? space : 3'b000)};
        3'd1:    b = op[1] ? addr[23:16] : {1'b0, addr[6:0]};
        3'd2:    b = op[1] ? addr[15:8] : ((op == OP_REG_WR) ? wdata : 8'h00);
        3'd3:    b = op[1] ? addr[7:0] : 8'h00;
        3'd4:    b = (op == OP_MEM_WR) ? wdata : 8'h00;
        default: b = 8'h00;
      endcase
    end
    return b;
  endfunction

  function automatic logic [2:0] lastByteIdx(input logic [1:0] op);
    logic [2:0] n;
    case (op)
      2'd0:    n = 3'd2;
      2'd1:    n = 3'd3;
      2'd2:    n = 3'd4;
      default: n = 3'd5;
    endcase
    return n + (USE_SYNC ? 3'd1 : 3'd0);
  endfunction

  state_t         r_state;
  logic [1:0]     r_op;
  logic [2:0]     r_space;
  logic [23:0]    r_addr;
  logic [7:0]     r_wdata;
  logic [2:0]     r_lastByte;
  logic [2:0]     r_byteIdx;
  logic [2:0]     r_bitCnt;
  logic [DW-1:0]  r_divCnt;
  logic [GW-1:0]  r_gapCnt;
  logic [7:0]     r_rxShift;
  logic           r_sclk;
  logic           r_mosi;
  logic           r_rspValid;
  logic [7:0]     r_rspData;

  logic [7:0] w_firstByte;
  logic [7:0] w_curByte;
  logic [7:0] w_nextByte;
  logic [2:0] w_nextBit;
  logic       w_divDone;

  assign w_firstByte = frameByte(bus.req_op, bus.req_space, bus.req_addr, bus.req_wdata, 3'd0);
  assign w_curByte   = frameByte(r_op, r_space, r_addr, r_wdata, r_byteIdx);
  assign w_nextByte  = frameByte(r_op, r_space, r_addr, r_wdata, r_byteIdx + 3'd1);
  assign w_nextBit   = r_bitCnt + 3'd1;
  assign w_divDone   = (r_divCnt == DIV_LAST);

  // mosi only moves on the sclk falling cycle, so the slave always sees it settled on the rise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_op       <= 2'd0;
      r_space    <= 3'd0;
      r_addr     <= 24'd0;
      r_wdata    <= 8'h00;
      r_lastByte <= 3'd0;
      r_byteIdx  <= 3'd0;
      r_bitCnt   <= 3'd0;
      r_divCnt   <= '0;
      r_gapCnt   <= '0;
      r_rxShift  <= 8'h00;
      r_sclk     <= 1'b0;
      r_mosi     <= 1'b0;
      r_rspValid <= 1'b0;
      r_rspData  <= 8'h00;
    end else begin
      r_rspValid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.req_valid) begin
            r_op       <= bus.req_op;
            r_space    <= bus.req_space;
            r_addr     <= bus.req_addr;
            r_wdata    <= bus.req_wdata;
            r_lastByte <= lastByteIdx(bus.req_op);
            r_byteIdx  <= 3'd0;
            r_bitCnt   <= 3'd0;
            r_divCnt   <= '0;
            r_sclk     <= 1'b0;
            r_mosi     <= w_firstByte[7];
            r_state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (!w_divDone) begin
            r_divCnt <= r_divCnt + DW'(1);
          end else begin
            r_divCnt <= '0;
            if (!r_sclk) begin
              r_sclk    <= 1'b1;
              r_rxShift <= {r_rxShift[6:0], bus.miso};
            end else begin
              r_sclk <= 1'b0;
              if (r_bitCnt != 3'd7) begin
                r_bitCnt <= w_nextBit;
                r_mosi   <= w_curByte[~w_nextBit];
              end else if (r_byteIdx != r_lastByte) begin
                r_bitCnt  <= 3'd0;
                r_byteIdx <= r_byteIdx + 3'd1;
                r_mosi    <= w_nextByte[7];
              end else begin
                // Read ops end on the read byte, so the shift register holds it now.
                r_mosi     <= 1'b0;
                r_rspValid <= 1'b1;
                r_rspData  <= r_op[0] ? r_rxShift : 8'h00;
                r_gapCnt   <= '0;
                r_state    <= GAP;
              end
            end
          end
        end
        GAP: begin
          if (r_gapCnt == GAP_LAST) r_state <= IDLE;
          else r_gapCnt <= r_gapCnt + GW'(1);
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = (r_state == IDLE);
  assign bus.busy      = (r_state != IDLE);
  assign bus.sclk      = r_sclk;
  assign bus.mosi      = r_mosi;
  assign bus.rsp_valid = r_rspValid;
  assign bus.rsp_data  = r_rspData;

endmodule

// File: doc/esp32_spi_master.md
# esp32_spi_master

SPI initiator for the ESP32 link register/memory protocol, the driving end of the FPGA-side slave connector. It accepts one register or memory transaction at a time on a valid/ready request port, serialises the frame on `sclk`/`mosi`, and captures the read byte from `miso`. It is used as the bench/loopback master and as the FPGA-side master toward SPI-slave peers.

## Interface
- `CLK_DIV`, 4: `clk` cycles per `sclk` half-period; minimum 1.
- `USE_SYNC`, 1: prefix every frame with sync byte 0xA5.
- `IDLE_GAP_CYC`, 16: idle `clk` cycles enforced between frames, with `sclk` low.
- `clk` in 1: system clock.
- `rst_n` in 1: reset, synchronous and active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: master can accept; equals (state==IDLE).
- `req_op` in 2: 0=REG_WR, 1=REG_RD, 2=MEM_WR, 3=MEM_RD.
- `req_space` in 3: memory space (MEM ops only).
- `req_addr` in 24: memory address; bits [6:0] are the register index for REG ops.
- `req_wdata` in 8: write byte.
- `rsp_valid` out 1: one-cycle pulse at frame end.
- `rsp_data` out 8: read byte (0x00 for writes); holds until the next `rsp_valid`.
- `busy` out 1: high in SHIFT and GAP.
- `sclk` out 1: SPI clock, mode 0, idle low.
- `mosi` out 1: MSB-first data.
- `miso` in 1: slave data, sampled on `sclk` rising edges.

## Operation
- Request is accepted on `req_valid && req_ready`. Op, space, addr, and wdata are latched; request inputs are ignored thereafter.
- CMD byte = {1'b1, op[1:0], 2'b00, space[2:0]}; space is forced to 0 for REG ops. This gives REG_WR=0x80, REG_RD=0xA0, MEM_WR=0xC0+space, MEM_RD=0xE0+space.
- Frame bytes, optionally preceded by [0xA5]:
  - REG_WR: CMD, {1'b0,idx}, DATA.
  - REG_RD: CMD, {1'b0,idx}, 0x00 (turnaround), 0x00 (read).
  - MEM_WR: CMD, A[23:16], A[15:8], A[7:0], DATA.
  - MEM_RD: CMD, A[23:16], A[15:8], A[7:0], 0x00 (turnaround), 0x00 (read).
- N = byte count, 3–7 depending on op and USE_SYNC. Byte counter is 3 bits; bit counter is 3 bits.
- States:
  - IDLE -> SHIFT on accept.
  - SHIFT -> GAP after the last falling edge of byte N.
  - GAP -> IDLE after IDLE_GAP_CYC cycles. IDLE_GAP_CYC=0 returns to IDLE on the next cycle.
- `miso` bits are shifted into an 8-bit register on every rising edge. For read ops, `rsp_data` is loaded from the last byte's shift register. For write ops, `rsp_data` is loaded with 0x00.
- No CRC; no chip select. Frames are delimited by the sync byte and the idle gap.

## Timing
- Reset values: `sclk`=0, `mosi`=0, `rsp_valid`=0, `rsp_data`=0x00, `busy`=0, state=IDLE (`req_ready`=1 on the first cycle after `rst_n` rises). Requests are not accepted while `rst_n`=0.
- Cycle A is the accept cycle.
  - A+1: `mosi` = bit7 of byte 0; `busy`=1; `sclk` low.
  - Each bit occupies 2*CLK_DIV cycles: `sclk` low CLK_DIV cycles, then high CLK_DIV cycles.
  - `mosi` changes only on the cycle `sclk` falls (or at A+1); it is never updated while `sclk` is high.
  - `miso` is sampled on the cycle `sclk` goes 0->1.
- Last falling edge falls at A+1+16*CLK_DIV*N. `rsp_valid` pulses that same cycle; `sclk` and `mosi` are 0 from then on.
- `req_ready` is low from A+1 through the end of GAP. The next accept is possible at the earliest IDLE_GAP_CYC+1 cycles after `rsp_valid`.
- Reset mid-frame: the next cycle has `sclk`=0, `mosi`=0, no `rsp_valid`, and the frame is discarded. The next frame starts from byte 0, including sync.
- `req_valid` held high across a transaction does not re-trigger until `req_ready` returns.

## Test plan
- REG_WR idx 5 data 0x3C, CLK_DIV=2, USE_SYNC=1: `mosi` bytes A5 80 05 3C; 4 bytes×8 bits×4 cycles = 128 cycles; `rsp_valid` at A+129 with `rsp_data`=0x00.
- REG_RD idx 0, slave model driving 0x41 in byte 4: `mosi` A5 A0 00 00 00; `rsp_data`=0x41.
- MEM_WR space 0 addr 0x000012 data 0x5A, then MEM_RD same address against the slave connector: `mosi` A5 C0 00 00 12 5A, then A5 E0 00 00 12 00 00; `rsp_data`=0x5A. MEM_RD space 1 returns 0xFF.
- Back-to-back requests, `req_valid` held high, IDLE_GAP_CYC=16: second accept exactly 17 cycles after the first `rsp_valid`; exactly 2 `rsp_valid` pulses.
- `rst_n` low for 1 cycle during byte 2: `sclk`=0 and `mosi`=0 next cycle; no `rsp_valid`; next request restarts with 0xA5.
- USE_SYNC=0, CLK_DIV=1, REG_RD idx 0x7F: `mosi` A0 7F 00 00; `rsp_valid` at A+65; `sclk` toggles every cycle.
